// File: rtl/synth_timing_pkg.sv
// -----------------------------------------------------------------------------
// synth_timing_pkg
// Shared definitions for the synth_engine slot timing generator.
//   - default geometry of the voice/envelope slot grid
//   - slot index typedefs sized from the default voice/envelope widths
//   - SLOTS_MAX: slots per frame with all voices active
//   - clamp_voices(): maps a requested active-voice count onto 1..vmax
// -----------------------------------------------------------------------------
package synth_timing_pkg;

    localparam int VOICES_DEF   = 8;
    localparam int V_ENVS_DEF   = 8;
    localparam int V_WIDTH_DEF  = 3;
    localparam int E_WIDTH_DEF  = 3;
    localparam int TAPS_DEF     = 3;
    localparam int FC_WIDTH_DEF = 16;

    localparam int SLOTS_MAX = VOICES_DEF * V_ENVS_DEF;

    typedef logic [V_WIDTH_DEF-1:0]             voice_idx_t;
    typedef logic [E_WIDTH_DEF-1:0]             env_idx_t;
    typedef logic [V_WIDTH_DEF+E_WIDTH_DEF-1:0] slot_idx_t;

    // Zero or out-of-range requests fall back to the full voice count so a
    // frame can never be empty or address voices that do not exist.
    function automatic int unsigned clamp_voices(input int unsigned req,
                                                 input int unsigned vmax);
        if ((req == 0) || (req > vmax)) begin
            return vmax;
        end
        return req;
    endfunction

endpackage

// File: rtl/timing_gen_mx_tap_pipe.sv
// -----------------------------------------------------------------------------
// timing_tap_pipe
// Fixed-depth delay line for the slot index. Shifts every clock; stage k
// holds the input delayed by k+1 clocks.
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset (clears all stages)
//   d_i      in   WIDTH        value entering the line
//   taps_o   out  DEPTH*WIDTH  stage k at [k*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module timing_tap_pipe #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [WIDTH-1:0]       d_i,
    output logic [DEPTH*WIDTH-1:0] taps_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign taps_o[g*WIDTH +: WIDTH] = stage_q[g];
    end

endmodule

// File: rtl/timing_gen_mx.sv
// -----------------------------------------------------------------------------
// timing_gen_mx
// Time-multiplex slot index generator at the head of the synth_engine slot
// pipeline. Walks every (voice, envelope) slot of a frame with a split
// voice/envelope counter, emits the linear slot index plus delayed copies
// for later pipeline stages, a one-cycle frame-wrap pulse and a frame count.
//
// Optional build macro:
//   TIMING_GEN_NEG_ZERO_EN  n_xxxx_zero becomes a negedge-registered flag
//                           (legacy timing: rises half a clock before the
//                           wrap edge, falls half a clock after the first
//                           advance out of slot 0, resets to 0). Undefined
//                           gives the posedge flag equal to (xxxx == 0).
//
// Ports:
//   sCLK_XVXENVS  in   1                      slot clock
//   reset_reg_N   in   1                      asynchronous active-low reset
//   run           in   1                      advance enable
//   n_voices      in   V_WIDTH+1              requested active voice count
//   vidx          out  V_WIDTH                current voice index
//   eidx          out  E_WIDTH                current envelope index
//   xxxx          out  V_WIDTH+E_WIDTH        vidx*V_ENVS + eidx
//   xxxx_tap      out  TAPS*(V_WIDTH+E_WIDTH) tap k = xxxx delayed k+1 clocks
//   n_xxxx_zero   out  1                      slot-zero flag
//   frame_wrap    out  1                      one-cycle pulse after each wrap
//   frame_cnt     out  FC_WIDTH               completed-frame count
// -----------------------------------------------------------------------------
module timing_gen_mx
    import synth_timing_pkg::*;
#(
    parameter int VOICES   = VOICES_DEF,
    parameter int V_ENVS   = V_ENVS_DEF,
    parameter int V_WIDTH  = V_WIDTH_DEF,
    parameter int E_WIDTH  = E_WIDTH_DEF,
    parameter int TAPS     = TAPS_DEF,
    parameter int FC_WIDTH = FC_WIDTH_DEF
) (
    input  logic                                sCLK_XVXENVS,
    input  logic                                reset_reg_N,
    input  logic                                run,
    input  logic [V_WIDTH:0]                    n_voices,
    output logic [V_WIDTH-1:0]                  vidx,
    output logic [E_WIDTH-1:0]                  eidx,
    output logic [V_WIDTH+E_WIDTH-1:0]          xxxx,
    output logic [TAPS*(V_WIDTH+E_WIDTH)-1:0]   xxxx_tap,
    output logic                                n_xxxx_zero,
    output logic                                frame_wrap,
    output logic [FC_WIDTH-1:0]                 frame_cnt
);

    localparam int SW = V_WIDTH + E_WIDTH;

    localparam logic [V_WIDTH-1:0]  V_ONE  = V_WIDTH'(1);
    localparam logic [E_WIDTH-1:0]  E_ONE  = E_WIDTH'(1);
    localparam logic [E_WIDTH-1:0]  E_LAST = E_WIDTH'(V_ENVS - 1);
    localparam logic [SW-1:0]       S_ONE  = SW'(1);
    localparam logic [V_WIDTH:0]    NV_ONE = (V_WIDTH+1)'(1);
    localparam logic [V_WIDTH:0]    NV_MAX = (V_WIDTH+1)'(VOICES);
    localparam logic [FC_WIDTH-1:0] FC_ONE = FC_WIDTH'(1);

    logic [V_WIDTH-1:0]  vidx_q,   vidx_d;
    logic [E_WIDTH-1:0]  eidx_q,   eidx_d;
    logic [SW-1:0]       xxxx_q,   xxxx_d;
    logic [V_WIDTH:0]    nv_lat_q, nv_lat_d;
    logic [FC_WIDTH-1:0] fcnt_q,   fcnt_d;
    logic                wrap_q,   wrap_d;

    logic [V_WIDTH:0]    nv_clamp;
    logic                last_slot;

    assign nv_clamp  = (V_WIDTH+1)'(clamp_voices(32'(n_voices), VOICES));
    assign last_slot = ({1'b0, vidx_q} == (nv_lat_q - NV_ONE)) && (eidx_q == E_LAST);

    // The linear index is kept as its own counter rather than recomputed from
    // vidx/eidx: stepping it by one is equivalent because an envelope wrap
    // lands on the next voice's slot 0, and it avoids a multiplier when
    // V_ENVS is not a power of two.
    always_comb begin
        vidx_d   = vidx_q;
        eidx_d   = eidx_q;
        xxxx_d   = xxxx_q;
        nv_lat_d = nv_lat_q;
        fcnt_d   = fcnt_q;
        wrap_d   = 1'b0;
        if (run) begin
            if (last_slot) begin
                vidx_d   = '0;
                eidx_d   = '0;
                xxxx_d   = '0;
                // Only the wrap edge re-samples the voice count, so a frame
                // never changes length once started.
                nv_lat_d = nv_clamp;
                fcnt_d   = fcnt_q + FC_ONE;
                wrap_d   = 1'b1;
            end else if (eidx_q == E_LAST) begin
                eidx_d = '0;
                vidx_d = vidx_q + V_ONE;
                xxxx_d = xxxx_q + S_ONE;
            end else begin
                eidx_d = eidx_q + E_ONE;
                xxxx_d = xxxx_q + S_ONE;
            end
        end
    end

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            vidx_q   <= '0;
            eidx_q   <= '0;
            xxxx_q   <= '0;
            nv_lat_q <= NV_MAX;
            fcnt_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            vidx_q   <= vidx_d;
            eidx_q   <= eidx_d;
            xxxx_q   <= xxxx_d;
            nv_lat_q <= nv_lat_d;
            fcnt_q   <= fcnt_d;
            wrap_q   <= wrap_d;
        end
    end

`ifdef TIMING_GEN_NEG_ZERO_EN
    // Legacy falling-edge flag: set at the negedge inside an advancing last
    // slot, held through slot 0, cleared at the first negedge after leaving it.
    logic zero_neg_q;

    always_ff @(negedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            zero_neg_q <= 1'b0;
        end else if (run && last_slot) begin
            zero_neg_q <= 1'b1;
        end else if (xxxx_q != '0) begin
            zero_neg_q <= 1'b0;
        end
    end

    assign n_xxxx_zero = zero_neg_q;
`else
    logic zero_q, zero_d;

    always_comb begin
        zero_d = (xxxx_d == '0);
    end

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign n_xxxx_zero = zero_q;
`endif

    // Taps shift every clock, independent of run, so a held index fills them.
    timing_tap_pipe #(
        .WIDTH (SW),
        .DEPTH (TAPS)
    ) u_tap_pipe (
        .clk_i  (sCLK_XVXENVS),
        .rst_ni (reset_reg_N),
        .d_i    (xxxx_q),
        .taps_o (xxxx_tap)
    );

    assign vidx       = vidx_q;
    assign eidx       = eidx_q;
    assign xxxx       = xxxx_q;
    assign frame_wrap = wrap_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_timing_gen_mx.sv
module tb_timing_gen_mx;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [3:0]  n_voices;
    logic [2:0]  vidx;
    logic [2:0]  eidx;
    logic [5:0]  xxxx;
    logic [17:0] xxxx_tap;
    logic        n_xxxx_zero;
    logic        frame_wrap;
    logic [15:0] frame_cnt;

    timing_gen_mx dut (
        .sCLK_XVXENVS (clk),
        .reset_reg_N  (rst_n),
        .run          (run),
        .n_voices     (n_voices),
        .vidx         (vidx),
        .eidx         (eidx),
        .xxxx         (xxxx),
        .xxxx_tap     (xxxx_tap),
        .n_xxxx_zero  (n_xxxx_zero),
        .frame_wrap   (frame_wrap),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int xxxx;
        int vidx;
        int eidx;
        int zero;
        int wrap;
        int fcnt;
        int t0;
        int t1;
        int t2;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference: a plain linear slot counter over a frame of nv*8 slots.
    int m_slot, m_nv, m_fcnt, m_wrap, m_t0, m_t1, m_t2;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_nv = 8; m_fcnt = 0; m_wrap = 0;
        m_t0 = 0; m_t1 = 0; m_t2 = 0;
    endtask

    // Drive one clock of stimulus and queue the state expected after the edge.
    task automatic step(input logic r, input logic [3:0] nv);
        exp_t e;
        @(negedge clk);
        run      = r;
        n_voices = nv;
        m_t2 = m_t1;
        m_t1 = m_t0;
        m_t0 = m_slot;
        m_wrap = 0;
        if (r) begin
            if (m_slot == m_nv * 8 - 1) begin
                m_slot = 0;
                m_fcnt = (m_fcnt + 1) % 65536;
                m_wrap = 1;
                m_nv   = ((nv == 0) || (nv > 8)) ? 8 : int'(nv);
            end else begin
                m_slot = m_slot + 1;
            end
        end
        e.xxxx = m_slot;
        e.vidx = m_slot / 8;
        e.eidx = m_slot % 8;
        e.zero = (m_slot == 0) ? 1 : 0;
        e.wrap = m_wrap;
        e.fcnt = m_fcnt;
        e.t0 = m_t0;
        e.t1 = m_t1;
        e.t2 = m_t2;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every clock edge that has an outstanding expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("xxxx",  int'(xxxx),             e.xxxx);
                check("vidx",  int'(vidx),             e.vidx);
                check("eidx",  int'(eidx),             e.eidx);
                check("wrap",  int'(frame_wrap),       e.wrap);
                check("fcnt",  int'(frame_cnt),        e.fcnt);
                check("tap0",  int'(xxxx_tap[5:0]),    e.t0);
                check("tap1",  int'(xxxx_tap[11:6]),   e.t1);
                check("tap2",  int'(xxxx_tap[17:12]),  e.t2);
`ifndef TIMING_GEN_NEG_ZERO_EN
                check("zero",  int'(n_xxxx_zero),      e.zero);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        run      = 1'b0;
        n_voices = 4'd8;
        model_reset();
        #12;
        check("rst_xxxx",  int'(xxxx),        0);
        check("rst_taps",  int'(xxxx_tap),    0);
        check("rst_wrap",  int'(frame_wrap),  0);
        check("rst_fcnt",  int'(frame_cnt),   0);
`ifndef TIMING_GEN_NEG_ZERO_EN
        check("rst_zero",  int'(n_xxxx_zero), 1);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Three full 64-slot frames.
        repeat (63) step(1'b1, 4'd8);
        settle();
        check("full_frame_last", int'(xxxx), 63);
        repeat (129) step(1'b1, 4'd8);
        settle();
        check("three_frames_fcnt", int'(frame_cnt),  3);
        check("three_frames_wrap", int'(frame_wrap), 1);
        check("three_frames_xxxx", int'(xxxx),       0);

        // Voice count dropped to 2 mid-frame: current frame still runs to 63.
        repeat (10) step(1'b1, 4'd8);
        repeat (53) step(1'b1, 4'd2);
        settle();
        check("midframe_change_x63", int'(xxxx), 63);
        step(1'b1, 4'd2);
        repeat (15) step(1'b1, 4'd2);
        settle();
        check("short_frame_x15", int'(xxxx), 15);
        step(1'b1, 4'd2);
        settle();
        check("short_frame_wrap", int'(frame_wrap), 1);
        check("short_frame_fcnt", int'(frame_cnt),  5);

        // n_voices = 0 and 15 both clamp to 8.
        repeat (16) step(1'b1, 4'd0);
        repeat (63) step(1'b1, 4'd0);
        settle();
        check("clamp0_x63", int'(xxxx), 63);
        step(1'b1, 4'd15);
        repeat (63) step(1'b1, 4'd15);
        settle();
        check("clamp15_x63", int'(xxxx), 63);
        step(1'b1, 4'd15);
        settle();
        check("clamp15_fcnt", int'(frame_cnt), 8);

        // Hold at the last slot for 5 clocks, then resume.
        repeat (63) step(1'b1, 4'd8);
        repeat (5) step(1'b0, 4'd8);
        settle();
        check("hold_xxxx", int'(xxxx),       63);
        check("hold_wrap", int'(frame_wrap), 0);
        check("hold_taps", int'(xxxx_tap),   {6'd63, 6'd63, 6'd63});
        step(1'b1, 4'd8);
        settle();
        check("resume_wrap", int'(frame_wrap), 1);
        check("resume_fcnt", int'(frame_cnt),  9);

        // Asynchronous reset mid-frame, between clock edges.
        repeat (37) step(1'b1, 4'd8);
        settle();
        check("pre_reset_x37", int'(xxxx), 37);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("async_rst_xxxx", int'(xxxx),       0);
        check("async_rst_vidx", int'(vidx),       0);
        check("async_rst_taps", int'(xxxx_tap),   0);
        check("async_rst_fcnt", int'(frame_cnt),  0);
        check("async_rst_wrap", int'(frame_wrap), 0);
`ifndef TIMING_GEN_NEG_ZERO_EN
        check("async_rst_zero", int'(n_xxxx_zero), 1);
`endif
        model_reset();
        n_voices = 4'd2;
        @(negedge clk);
        rst_n = 1'b1;
        // First frame after reset uses the full voice count.
        repeat (63) step(1'b1, 4'd2);
        settle();
        check("post_reset_x63", int'(xxxx), 63);
        step(1'b1, 4'd2);
        repeat (16) step(1'b1, 4'd2);
        settle();
        check("post_reset_fcnt", int'(frame_cnt), 2);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
